// File: rtl/logic_reduce_unit_if.sv
// Operand/result handshake bundle for logic_reduce_unit.
// The slave modport is the reduce unit; the master modport is whoever drives beats and takes results.
interface logic_reduce_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic             mode;
    logic             last;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [7:0]       beats;
    logic             truncated;

    modport slave (
        input  in_valid, op, mode, last, a, b, out_ready,
        output in_ready, out_valid, result, zero, beats, truncated
    );

    modport master (
        output in_valid, op, mode, last, a, b, out_ready,
        input  in_ready, out_valid, result, zero, beats, truncated
    );
endinterface

// File: rtl/logic_reduce_unit.sv
// Bitwise AND/OR/XOR/NOR unit: combines a op b per beat, optionally folding a multi-beat
// transaction into one registered result that is held until the consumer takes it.
module logic_reduce_unit #(
    parameter int WIDTH     = 32,
    parameter int MAX_BEATS = 8
) (
    input logic                 clk,
    input logic                 reset_n,
    logic_reduce_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_BEATS);

    // NOR is applied only once, at the output; accumulation uses plain OR.
    function automatic logic [WIDTH-1:0] op_base(input logic [1:0]       sel,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        case (sel)
            2'b00:   op_base = x & y;
            2'b01:   op_base = x | y;
            2'b10:   op_base = x ^ y;
            default: op_base = x | y;
        endcase
    endfunction

    state_t           state;
    state_t           state_nxt;
    logic             ready;
    logic             valid;
    logic             accept;
    logic [1:0]       op_eff;
    logic [WIDTH-1:0] term;
    logic [7:0]       beats_inc;
    logic             close_acc;

    logic [WIDTH-1:0] acc_p0;
    logic [1:0]       op_p0;
    logic [7:0]       beats_p0;
    logic             trunc_p0;
    logic [WIDTH-1:0] res;

    assign accept    = bus.in_valid && ready;
    assign op_eff    = (state == IDLE) ? bus.op : op_p0;
    assign term      = op_base(op_eff, bus.a, bus.b);
    assign beats_inc = beats_p0 + 8'd1;
    assign close_acc = bus.last || (beats_inc == MAX_CNT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (!bus.mode || bus.last) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept && close_acc) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        valid = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            ACC:     ready = 1'b1;
            HOLD:    valid = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Stage p0: accumulator and transaction attributes, captured only on accepted beats.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_p0   <= '0;
            op_p0    <= 2'b00;
            beats_p0 <= 8'd0;
            trunc_p0 <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                acc_p0   <= term;
                op_p0    <= bus.op;
                beats_p0 <= 8'd1;
                trunc_p0 <= 1'b0;
            end else begin
                acc_p0   <= op_base(op_p0, acc_p0, term);
                beats_p0 <= beats_inc;
                trunc_p0 <= !bus.last && (beats_inc == MAX_CNT);
            end
        end
    end

    assign res           = (op_p0 == 2'b11) ? ~acc_p0 : acc_p0;
    assign bus.result    = res;
    assign bus.zero      = ~|res;
    assign bus.beats     = beats_p0;
    assign bus.truncated = trunc_p0;
    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
endmodule

// File: tb/tb_logic_reduce_unit.sv
// Directed and randomized bench for logic_reduce_unit against a fold-based reference model.
module tb_logic_reduce_unit;
    localparam int WIDTH     = 32;
    localparam int MAX_BEATS = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic_reduce_unit_if #(.WIDTH(WIDTH)) bus ();

    logic_reduce_unit #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] va[$];
    logic [31:0] vb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] base_op(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return x | y;
        endcase
    endfunction

    // Result of a whole transaction: fold every beat's (a op b) with the base op; NOR inverts the fold.
    function automatic logic [31:0] model_result(input logic [1:0] o, input int n);
        logic [31:0] acc;
        acc = base_op(o, va[0], vb[0]);
        for (int k = 1; k < n; k++) acc = base_op(o, acc, base_op(o, va[k], vb[k]));
        return (o == 2'b11) ? ~acc : acc;
    endfunction

    task automatic run_txn(input logic [1:0] top, input logic tmode, input int n,
                           input bit use_last, input int gap, input int hold);
        int nb;
        logic [31:0] er;
        bit etr;
        nb  = !tmode ? 1 : (use_last ? n : MAX_BEATS);
        etr = tmode && !use_last;
        while (va.size() < nb) begin
            va.push_back($urandom);
            vb.push_back($urandom);
        end
        for (int k = 0; k < nb; k++) begin
            if (k > 0 && gap > 0) begin
                bus.in_valid = 1'b0;
                repeat (gap) begin
                    tick();
                    check("gap_out_valid", 64'(bus.out_valid), 64'd0);
                end
            end
            check("beat_in_ready", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b1;
            bus.a        = va[k];
            bus.b        = vb[k];
            bus.op       = (k == 0) ? top : 2'($urandom);
            bus.mode     = (k == 0) ? tmode : 1'($urandom);
            bus.last     = tmode ? (use_last && k == nb - 1) : 1'($urandom);
            tick();
            if (k < nb - 1) check("mid_out_valid", 64'(bus.out_valid), 64'd0);
        end
        er = model_result(top, nb);
        bus.in_valid = 1'b1;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.last = 1'b1;
        check("out_valid", 64'(bus.out_valid), 64'd1);
        check("result", 64'(bus.result), 64'(er));
        check("beats", 64'(bus.beats), 64'(nb));
        check("zero", 64'(bus.zero), 64'(er == 32'd0));
        check("truncated", 64'(bus.truncated), 64'(etr));
        check("hold_in_ready", 64'(bus.in_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_result", 64'(bus.result), 64'(er));
            check("bp_beats", 64'(bus.beats), 64'(nb));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.last      = 1'b0;
        check("release_out_valid", 64'(bus.out_valid), 64'd0);
        check("release_in_ready", 64'(bus.in_ready), 64'd1);
        va.delete();
        vb.delete();
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 2'b00;
        bus.mode = 1'b0; bus.last = 1'b0; bus.a = '0; bus.b = '0;
        reset_n = 1'b0;
        repeat (2) tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_beats", 64'(bus.beats), 64'd0);
        check("rst_truncated", 64'(bus.truncated), 64'd0);
        reset_n = 1'b1;
        tick();

        va.push_back(32'hF0F0_F0F0); vb.push_back(32'hFF00_FF00);
        run_txn(2'b00, 1'b0, 1, 1'b0, 0, 0);
        va.push_back(32'h5555_5555); vb.push_back(32'hAAAA_AAAA);
        run_txn(2'b00, 1'b0, 1, 1'b0, 0, 0);
        va = '{32'd1, 32'd4, 32'd8}; vb = '{32'd2, 32'd0, 32'd8};
        run_txn(2'b10, 1'b1, 3, 1'b1, 0, 1);
        for (int k = 0; k < MAX_BEATS; k++) begin va.push_back('0); vb.push_back('0); end
        run_txn(2'b11, 1'b1, MAX_BEATS, 1'b0, 0, 0);
        run_txn(2'b01, 1'b1, 4, 1'b1, 1, 5);

        // Reset in the middle of a reduce discards the partial result.
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1; bus.op = 2'b01; bus.mode = 1'b1; bus.last = 1'b0;
            bus.a = $urandom; bus.b = $urandom;
            tick();
        end
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_beats", 64'(bus.beats), 64'd0);
        repeat (3) begin
            tick();
            check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        end
        va.push_back(32'd1); vb.push_back(32'd2);
        run_txn(2'b01, 1'b0, 1, 1'b0, 0, 0);

        // Reset while a result is pending in HOLD.
        bus.in_valid = 1'b1; bus.op = 2'b10; bus.mode = 1'b0;
        bus.a = $urandom; bus.b = $urandom;
        tick();
        bus.in_valid = 1'b0;
        check("pre_rst_hold", 64'(bus.out_valid), 64'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("hold_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("hold_rst_truncated", 64'(bus.truncated), 64'd0);
        tick();
        check("hold_rst_stays_idle", 64'(bus.out_valid), 64'd0);

        for (int r = 0; r < 30; r++) begin
            run_txn(2'($urandom), 1'($urandom), int'($urandom_range(1, MAX_BEATS)),
                    bit'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
